// File: rtl/hash_round_timer_if.sv
// Control/status bundle of the hash round timer: job requests in, round and pass sequencing out.
interface hash_round_timer_if #(
    parameter int CNT_W  = 7,
    parameter int PASS_W = 1
);
    logic              start;
    logic              hold;
    logic              abort;
    logic              busy;
    logic [CNT_W-1:0]  round_idx;
    logic [PASS_W-1:0] pass_idx;
    logic              round_valid;
    logic              last_round;
    logic              pass_done;
    logic              done;

    modport master (
        output start, hold, abort,
        input  busy, round_idx, pass_idx, round_valid, last_round, pass_done, done
    );

    modport slave (
        input  start, hold, abort,
        output busy, round_idx, pass_idx, round_valid, last_round, pass_done, done
    );
endinterface

// File: rtl/hash_round_timer.sv
// Round/pass sequencer for a multi-pass hash core: steps ROUNDS rounds per pass, PASSES passes per job,
// with datapath stall (hold), cancellation (abort) and back-to-back job restart from DONE.
module hash_round_timer #(
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 7,
    parameter int PASSES = 2,
    parameter int PASS_W = 1
) (
    input  logic               clk,
    input  logic               n_rst,
    hash_round_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  ROUND_LAST = CNT_W'(ROUNDS - 1);
    localparam logic [PASS_W-1:0] PASS_LAST  = PASS_W'(PASSES - 1);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   round_r;
    logic [CNT_W-1:0]   round_s;
    logic [PASS_W-1:0]  pass_r;
    logic [PASS_W-1:0]  pass_s;
    logic               pass_done_r;
    logic               run_s;
    logic               valid_s;
    logic               last_s;

    assign run_s   = (state_r == ST_RUN);
    assign valid_s = run_s & ~bus.hold;
    assign last_s  = valid_s & (round_r == ROUND_LAST);

    assign bus.busy        = run_s;
    assign bus.round_valid = valid_s;
    assign bus.last_round  = last_s;
    assign bus.round_idx   = round_r;
    assign bus.pass_idx    = pass_r;
    assign bus.pass_done   = pass_done_r;
    assign bus.done        = (state_r == ST_DONE);

    // Next-state and index update; abort overrides everything, and every exit from RUN leaves indices at zero.
    always_comb begin
        state_s = state_r;
        round_s = round_r;
        pass_s  = pass_r;
        if (bus.abort) begin
            state_s = ST_IDLE;
            round_s = '0;
            pass_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_s = ST_RUN;
                        round_s = '0;
                        pass_s  = '0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.hold) begin
                        state_s = ST_RUN;
                    end else if (round_r != ROUND_LAST) begin
                        round_s = round_r + CNT_W'(1);
                    end else if (pass_r != PASS_LAST) begin
                        round_s = '0;
                        pass_s  = pass_r + PASS_W'(1);
                    end else begin
                        state_s = ST_DONE;
                        round_s = '0;
                        pass_s  = '0;
                    end
                end
                ST_DONE: begin
                    // start here chains the next job without an IDLE gap
                    if (bus.start) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                    round_s = '0;
                    pass_s  = '0;
                end
                default: begin
                    state_s = ST_IDLE;
                    round_s = '0;
                    pass_s  = '0;
                end
            endcase
        end
    end

    // State, indices and the delayed pass-complete pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= ST_IDLE;
            round_r     <= '0;
            pass_r      <= '0;
            pass_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            round_r     <= round_s;
            pass_r      <= pass_s;
            pass_done_r <= last_s & ~bus.abort;
        end
    end
endmodule

// File: tb/tb_hash_round_timer.sv
// Scoreboard bench: two timers (64x2 and 5x3) are driven per cycle; a job-progress model pushes expected outputs.
module tb_hash_round_timer;
    localparam int R0 = 64;
    localparam int C0 = 7;
    localparam int P0 = 2;
    localparam int W0 = 1;
    localparam int R1 = 5;
    localparam int C1 = 3;
    localparam int P1 = 3;
    localparam int W1 = 2;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    hash_round_timer_if #(.CNT_W(C0), .PASS_W(W0)) bus0 ();
    hash_round_timer_if #(.CNT_W(C1), .PASS_W(W1)) bus1 ();

    hash_round_timer #(.ROUNDS(R0), .CNT_W(C0), .PASSES(P0), .PASS_W(W0)) u_dut0 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus0)
    );
    hash_round_timer #(.ROUNDS(R1), .CNT_W(C1), .PASSES(P1), .PASS_W(W1)) u_dut1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus1)
    );

    // job-progress model: elapsed counts consumed rounds since the job started
    int  rr [2] = '{R0, R1};
    int  pp [2] = '{P0, P1};
    bit  m_active [2];
    int  m_el [2];
    bit  m_done [2];
    bit  m_pd [2];
    bit  in_start [2];
    bit  in_hold [2];
    bit  in_abort [2];

    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt [2];
    int first_done [2];
    int pd_cnt [2];
    int rv_cnt [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_vec(input int id);
        logic [31:0] v;
        int ri;
        int pi;
        bit rv;
        v  = '0;
        ri = m_active[id] ? (m_el[id] % rr[id]) : 0;
        pi = m_active[id] ? (m_el[id] / rr[id]) : 0;
        rv = m_active[id] && !in_hold[id];
        v[28] = m_active[id];
        v[27] = rv;
        v[26] = rv && (ri == rr[id] - 1);
        v[25] = m_pd[id];
        v[24] = m_done[id];
        v[12 +: 8]  = 8'(pi);
        v[0 +: 12]  = 12'(ri);
        return v;
    endfunction

    function automatic logic [31:0] obs_vec0();
        logic [31:0] v;
        v = '0;
        v[28] = bus0.busy;
        v[27] = bus0.round_valid;
        v[26] = bus0.last_round;
        v[25] = bus0.pass_done;
        v[24] = bus0.done;
        v[12 +: W0] = bus0.pass_idx;
        v[0 +: C0]  = bus0.round_idx;
        return v;
    endfunction

    function automatic logic [31:0] obs_vec1();
        logic [31:0] v;
        v = '0;
        v[28] = bus1.busy;
        v[27] = bus1.round_valid;
        v[26] = bus1.last_round;
        v[25] = bus1.pass_done;
        v[24] = bus1.done;
        v[12 +: W1] = bus1.pass_idx;
        v[0 +: C1]  = bus1.round_idx;
        return v;
    endfunction

    task automatic model_edge(input int id);
        bit lr;
        lr = m_active[id] && !in_hold[id] && ((m_el[id] % rr[id]) == rr[id] - 1);
        m_pd[id] = lr && !in_abort[id];
        if (in_abort[id]) begin
            m_active[id] = 1'b0;
            m_el[id]     = 0;
            m_done[id]   = 1'b0;
        end else if (m_active[id]) begin
            m_done[id] = 1'b0;
            if (!in_hold[id]) begin
                m_el[id]++;
                if (m_el[id] == rr[id] * pp[id]) begin
                    m_active[id] = 1'b0;
                    m_el[id]     = 0;
                    m_done[id]   = 1'b1;
                end
            end
        end else begin
            m_done[id] = 1'b0;
            if (in_start[id]) begin
                m_active[id] = 1'b1;
                m_el[id]     = 0;
            end
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            done_cnt[i]   = 0;
            first_done[i] = -1;
            pd_cnt[i]     = 0;
            rv_cnt[i]     = 0;
        end
        cyc = 0;
    endtask

    // one clock cycle: entered and left just after a falling edge
    task automatic step(input bit s0, input bit h0, input bit a0, input bit s1, input bit h1, input bit a1);
        in_start[0] = s0; in_hold[0] = h0; in_abort[0] = a0;
        in_start[1] = s1; in_hold[1] = h1; in_abort[1] = a1;
        bus0.start = s0; bus0.hold = h0; bus0.abort = a0;
        bus1.start = s1; bus1.hold = h1; bus1.abort = a1;
        exp_q.push_back(expect_vec(0));
        exp_q.push_back(expect_vec(1));
        #2;
        check_eq("outs0", obs_vec0(), exp_q.pop_front());
        check_eq("outs1", obs_vec1(), exp_q.pop_front());
        if (bus0.done === 1'b1) begin
            done_cnt[0]++;
            if (first_done[0] < 0) first_done[0] = cyc;
        end
        if (bus1.done === 1'b1) begin
            done_cnt[1]++;
            if (first_done[1] < 0) first_done[1] = cyc;
        end
        if (bus1.pass_done === 1'b1) pd_cnt[1]++;
        if (bus1.round_valid === 1'b1) rv_cnt[1]++;
        if (bus0.pass_done === 1'b1) pd_cnt[0]++;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        cyc++;
        @(negedge clk);
    endtask

    // asynchronous reset between edges; outputs must clear before any clock edge
    task automatic reset_pulse();
        bus0.start = 1'b0; bus0.hold = 1'b0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.hold = 1'b0; bus1.abort = 1'b0;
        #3 n_rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_el[i] = 0; m_done[i] = 1'b0; m_pd[i] = 1'b0;
            in_start[i] = 1'b0; in_hold[i] = 1'b0; in_abort[i] = 1'b0;
        end
        exp_q.push_back(expect_vec(0));
        exp_q.push_back(expect_vec(1));
        check_eq("rst0", obs_vec0(), exp_q.pop_front());
        check_eq("rst1", obs_vec1(), exp_q.pop_front());
        @(posedge clk);
        #3 n_rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_rst = 1'b1;
        @(negedge clk);
        reset_pulse();

        // idle: hold and abort have no effect, abort beats start
        clear_stats();
        step(0, 1, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0, 1);
        step(0, 0, 1, 0, 0, 0);

        // nominal jobs on both; stray starts during RUN are ignored
        clear_stats();
        for (int i = 0; i < 134; i++)
            step(i == 0 || i == 40 || i == 100, 1'b0, 1'b0, i == 0 || i == 7, 1'b0, 1'b0);
        check_eq("done_cyc0", 32'(first_done[0]), 32'(1 + P0 * R0));
        check_eq("done_cnt0", 32'(done_cnt[0]), 32'd1);
        check_eq("done_cyc1", 32'(first_done[1]), 32'(1 + P1 * R1));
        check_eq("pd_cnt1", 32'(pd_cnt[1]), 32'(P1));
        check_eq("rv_cnt1", 32'(rv_cnt[1]), 32'(P1 * R1));

        // hold for three cycles at round 10; small timer stalled mid-pass
        clear_stats();
        for (int i = 0; i < 136; i++)
            step(i == 0, i >= 11 && i <= 13, 1'b0, i == 0, i == 6 || i == 7, 1'b0);
        check_eq("hold_done0", 32'(first_done[0]), 32'(1 + P0 * R0 + 3));
        check_eq("hold_done1", 32'(first_done[1]), 32'(1 + P1 * R1 + 2));

        // abort coincident with the last round of pass 0; abort small timer in DONE
        clear_stats();
        for (int i = 0; i < 140; i++)
            step(i == 0, 1'b0, i == 64, i == 0, 1'b0, i == 16);
        check_eq("abort_done0", 32'(done_cnt[0]), 32'd0);
        check_eq("abort_pd0", 32'(pd_cnt[0]), 32'd0);
        check_eq("abort_done1", 32'(done_cnt[1]), 32'd1);

        // start held high: jobs run back to back through DONE
        clear_stats();
        for (int i = 0; i < 261; i++)
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("b2b_done0", 32'(done_cnt[0]), 32'd2);
        check_eq("b2b_first0", 32'(first_done[0]), 32'(1 + P0 * R0));

        // reset in the middle of a job, then the block waits for a fresh start
        clear_stats();
        for (int i = 0; i < 20; i++)
            step(i == 0 || i == 10, 1'b0, 1'b0, i == 0, 1'b0, 1'b0);
        reset_pulse();
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(i == 0, 1'b0, 1'b0, i == 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hash_round_timer.md
HASH_ROUND_TIMER -- requirements
Module: hash_round_timer

Interface
REQ-001 Parameter ROUNDS, default 64: rounds per hash pass; legal range ≥ 2.
REQ-002 Parameter CNT_W, default 7: round index width; SHALL satisfy 2^CNT_W ≥ ROUNDS.
REQ-003 Parameter PASSES, default 2: passes per job (2 = double SHA-256); legal range ≥ 1.
REQ-004 Parameter PASS_W, default 1: pass index width; SHALL satisfy 2^PASS_W ≥ PASSES.
REQ-005 clk  input  1  single system clock; all state changes on the rising edge.
REQ-006 n_rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin a job; honoured in IDLE or DONE only.
REQ-008 hold  input  1  freeze round/pass advance while in RUN (datapath stall).
REQ-009 abort  input  1  cancel the job and return to IDLE.
REQ-010 busy  output  1  high in RUN.
REQ-011 round_idx  output  CNT_W  current round, 0..ROUNDS-1, zero-based with no offset.
REQ-012 pass_idx  output  PASS_W  current pass, 0..PASSES-1.
REQ-013 round_valid  output  1  round_idx is consumed this cycle.
REQ-014 last_round  output  1  final round of the current pass is consumed this cycle.
REQ-015 pass_done  output  1  one-cycle registered pulse after each completed pass.
REQ-016 done  output  1  one-cycle pulse; the job completed.

Function
REQ-017 FSM states: IDLE, RUN, DONE, and no others. Unreachable encodings SHALL return to IDLE.
REQ-018 IDLE: when start=1 and abort=0 -> RUN; round_idx=0 and pass_idx=0 on entry.
REQ-019 RUN, hold=0, round_idx<ROUNDS-1: round_idx increments by 1.
REQ-020 RUN, hold=0, round_idx=ROUNDS-1, pass_idx<PASSES-1: round_idx wraps to 0 and pass_idx increments.
REQ-021 RUN, hold=0, round_idx=ROUNDS-1, pass_idx=PASSES-1: -> DONE; round_idx and pass_idx clear to 0.
REQ-022 RUN, hold=1: round_idx, pass_idx and state hold their values; hold has no effect outside RUN.
REQ-023 DONE lasts exactly one cycle, with done=1. If start=1 and abort=0 -> RUN with indices at 0 (back-to-back jobs); otherwise -> IDLE.
REQ-024 Combinational outputs: round_valid = RUN & ~hold; last_round = round_valid & (round_idx == ROUNDS-1); busy = RUN.
REQ-025 pass_done is registered: it equals last_round of the previous cycle, unless abort was asserted in that previous cycle.
REQ-026 abort=1 in any state -> IDLE next cycle; indices clear; done and pass_done are not produced. abort takes priority over start and hold.
REQ-027 start in RUN is ignored.
REQ-028 Timing with no hold, start at cycle 0:
  - round k of pass p is valid at cycle 1 + p*ROUNDS + k;
  - done is high at cycle 1 + PASSES*ROUNDS;
  - the final pass_done coincides with done.
REQ-029 No counter SHALL exceed ROUNDS-1 or PASSES-1 at any time.

Reset
REQ-030 n_rst=0: the block SHALL immediately enter IDLE, with round_idx=0, pass_idx=0 and pass_done=0. busy, round_valid, last_round and done SHALL be 0.
REQ-031 Reset asserted mid-job discards the job; after release the block waits for a new start.

Verification
REQ-032 Defaults, start pulse at cycle 0, hold=0 -> round_idx runs 0..63 during cycles 1..64 and 65..128, with pass_idx 0 then 1. last_round is high at cycles 64 and 128. pass_done is high at cycles 65 and 129. done=1 at cycle 129 only.
REQ-033 hold=1 for 3 cycles while round_idx=10 -> round_idx stays at 10 and round_valid=0 for those 3 cycles. done shifts to cycle 132.
REQ-034 abort at round_idx=63, pass_idx=0 (simultaneous with last_round) -> IDLE next cycle, pass_done=0, done never asserts, indices read 0.
REQ-035 start held high through DONE -> RUN is re-entered the next cycle with round_idx=0 and pass_idx=0, with no IDLE cycle between jobs.
REQ-036 n_rst pulsed low asynchronously mid-RUN (between clock edges) -> outputs read 0 before the next edge. start pulses asserted in RUN are ignored.
REQ-037 ROUNDS=5, CNT_W=3, PASSES=3, PASS_W=2 -> 15 valid rounds, 3 pass_done pulses, done at cycle 16.
